// File: rtl/tmds_encoder_rgb_if.sv
// rtl/tmds_encoder_rgb_if.sv - pixel-in / TMDS-symbol-out bundle for the RGB TMDS encoder
interface tmds_encoder_rgb_if;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       de;
    logic       hs;
    logic       vs;
    logic [9:0] tmds_r;
    logic [9:0] tmds_g;
    logic [9:0] tmds_b;

    modport master (
        output r, g, b, de, hs, vs,
        input  tmds_r, tmds_g, tmds_b
    );

    modport slave (
        input  r, g, b, de, hs, vs,
        output tmds_r, tmds_g, tmds_b
    );
endinterface

// File: rtl/tmds_encoder_rgb.sv
// rtl/tmds_encoder_rgb.sv - three-channel DVI TMDS 8b/10b encoder (optional extra output stage: TMDS_OUT_REG_EN)
module tmds_encoder_rgb #(
    parameter logic [9:0] RST_CODE = 10'h354
) (
    input  logic              clk_pixel,
    input  logic              reset_n,
    tmds_encoder_rgb_if.slave vid
);

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Transition-minimised 9-bit word; bit 8 set means the XOR chain was used.
    function automatic logic [8:0] min_trans(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] q;
        n1       = ones8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    function automatic logic [9:0] ctrl_code(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = 10'h354;
            2'b01:   s = 10'h0AB;
            2'b10:   s = 10'h154;
            default: s = 10'h2AB;
        endcase
        return s;
    endfunction

    // Channel index 0/1/2 = blue/green/red, matching TMDS channel numbering.
    logic [7:0] pix [3];
    logic [9:0] sym [3];

    assign pix[0] = vid.b;
    assign pix[1] = vid.g;
    assign pix[2] = vid.r;

    assign vid.tmds_b = sym[0];
    assign vid.tmds_g = sym[1];
    assign vid.tmds_r = sym[2];

    logic       de_s1;
    logic [1:0] ctrl_s1;

    // Stage 1: delay de and sync alongside the q_m words so they stay aligned.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            de_s1   <= 1'b0;
            ctrl_s1 <= 2'b00;
        end else begin
            de_s1   <= vid.de;
            ctrl_s1 <= {vid.vs, vid.hs};
        end
    end

    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        logic        [8:0] q_m;
        logic        [1:0] ctrl;
        logic        [3:0] n1;
        logic        [3:0] n0;
        logic signed [4:0] bal;
        logic signed [4:0] cnt;
        logic signed [4:0] cnt_nxt;
        logic        [9:0] sym_s2;
        logic        [9:0] sym_nxt;

        // Only blue carries sync; green and red always send control code 00.
        assign ctrl = (ch == 0) ? ctrl_s1 : 2'b00;

        // Stage 1: transition minimisation.
        always_ff @(posedge clk_pixel or negedge reset_n) begin
            if (!reset_n) begin
                q_m <= '0;
            end else begin
                q_m <= min_trans(pix[ch]);
            end
        end

        // Stage 2 next-state: pick inversion to pull running disparity toward zero.
        always_comb begin
            n1      = ones8(q_m[7:0]);
            n0      = 4'd8 - n1;
            bal     = $signed({1'b0, n1}) - $signed({1'b0, n0});
            sym_nxt = ctrl_code(ctrl);
            cnt_nxt = '0;
            if (de_s1) begin
                if ((cnt == 5'sd0) || (n1 == n0)) begin
                    sym_nxt = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
                    cnt_nxt = q_m[8] ? (cnt + bal) : (cnt - bal);
                end else if ((!cnt[4] && (n1 > n0)) || (cnt[4] && (n0 > n1))) begin
                    sym_nxt = {1'b1, q_m[8], ~q_m[7:0]};
                    cnt_nxt = cnt - bal + (q_m[8] ? 5'sd2 : 5'sd0);
                end else begin
                    sym_nxt = {1'b0, q_m[8], q_m[7:0]};
                    cnt_nxt = cnt + bal - (q_m[8] ? 5'sd0 : 5'sd2);
                end
            end
        end

        // Stage 2: output symbol and disparity counter.
        always_ff @(posedge clk_pixel or negedge reset_n) begin
            if (!reset_n) begin
                sym_s2 <= RST_CODE;
                cnt    <= '0;
            end else begin
                sym_s2 <= sym_nxt;
                cnt    <= cnt_nxt;
            end
        end

`ifdef TMDS_OUT_REG_EN
        logic [9:0] sym_s3;

        // Stage 3: retiming register in front of the serializer.
        always_ff @(posedge clk_pixel or negedge reset_n) begin
            if (!reset_n) begin
                sym_s3 <= RST_CODE;
            end else begin
                sym_s3 <= sym_s2;
            end
        end

        assign sym[ch] = sym_s3;
`else
        assign sym[ch] = sym_s2;
`endif
    end

endmodule
